// File: rtl/nibble_add_sched.sv
// nibble_add_sched
//   Round-robin sequencer sharing a single 4-bit adder among NUM_REQ
//   requesters. An accepted request is added nibble-serially (LSB nibble
//   first), with the carry chained between passes. The result is then held on
//   the response port until the consumer takes it.
//
//   Optional build macro: NIBBLE_ADD_SCHED_SAT_EN. When it is defined, a final
//   carry of 1 forces rsp_sum to all-ones (unsigned saturation).
//
//   Ports
//     clk, reset   clock; asynchronous active-high reset
//     req_valid    [NUM_REQ]        per-requester valid
//     req_a/req_b  [NUM_REQ*WIDTH]  operands; requester i at [i*WIDTH +: WIDTH]
//     req_ready    [NUM_REQ]        one-hot accept strobe (IDLE only)
//     rsp_valid/rsp_ready           response handshake
//     rsp_sum, rsp_cout, rsp_id     result, MSB-nibble carry, served requester
//     busy                          high in ADD and RESP
module nibble_add_sched #(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 16,
  localparam int NIBBLES = WIDTH / 4,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic [IDW-1:0]           rsp_id,
  output logic                     busy
);

  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, ADD, RESP} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q, rsp_valid_q, busy_q;
  logic [IDW-1:0]   id_q, last_q;
  logic [CW-1:0]    cnt_q;

  // Round-robin pick: first set valid bit above last_q, wrapping around.
  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;

  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_q) + off) % NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  // Operands shift right one nibble per pass, so the active nibble is always
  // bits [3:0]. Sum nibbles enter at the top and end up aligned after the
  // final pass.
  logic [4:0]       nib;
  logic [WIDTH-1:0] sum_d;

  always_comb begin
    nib   = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, carry_q};
    sum_d = (sum_q >> 4) | (WIDTH'(nib[3:0]) << (WIDTH - 4));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      id_q        <= '0;
      last_q      <= IDW'(NUM_REQ - 1);
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (gnt_found) begin
          a_q     <= req_a[gnt_idx*WIDTH +: WIDTH];
          b_q     <= req_b[gnt_idx*WIDTH +: WIDTH];
          id_q    <= gnt_idx;
          last_q  <= gnt_idx;
          carry_q <= 1'b0;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= ADD;
        end
        ADD: begin
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          carry_q <= nib[4];
          cnt_q   <= cnt_q + 1'b1;
          sum_q   <= sum_d;
          if (cnt_q == CW'(NIBBLES - 1)) begin
            cout_q      <= nib[4];
`ifdef NIBBLE_ADD_SCHED_SAT_EN
            if (nib[4]) sum_q <= '1;
`endif
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nibble_add_sched.sv
// Directed bench for nibble_add_sched (NUM_REQ=4, WIDTH=16). Expected
// responses are pushed to a scoreboard queue when stimulus is set up, and they
// are popped and compared whenever a response handshake is seen.
module tb_nibble_add_sched;
  localparam int NR = 4;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [NR*W-1:0] req_a, req_b;
  logic [NR-1:0] req_ready;
  logic          rsp_valid, rsp_ready, rsp_cout, busy;
  logic [W-1:0]  rsp_sum;
  logic [1:0]    rsp_id;

  nibble_add_sched #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a),
    .req_b(req_b), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] id, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    logic [W:0] full;
    full   = {1'b0, a} + {1'b0, b};
    e.id   = id;
    e.cout = full[W];
    e.sum  = full[W-1:0];
`ifdef NIBBLE_ADD_SCHED_SAT_EN
    if (full[W]) e.sum = '1;
`endif
    return e;
  endfunction

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic push(input int i);
    sb.push_back(model(2'(i), req_a[i*W +: W], req_b[i*W +: W]));
  endtask

  // Negedge sample point. A response handshake pops and checks the scoreboard.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_id), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
        chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    adv();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_drain_left"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Check the outputs after reset.
    sample();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_sum", 32'(rsp_sum), 0);
    chk("rst_cout", 32'(rsp_cout), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_busy", 32'(busy), 0);
    adv();

    // Single add with latency; operand change after accept must be ignored.
    set_op(0, 16'h1234, 16'h0FFF); req_valid = 4'b0001; push(0);
    sample();
    chk("t1_ready", 32'(req_ready), 32'b0001);
    adv();
    req_valid = '0; set_op(0, 16'hDEAD, 16'hBEEF);
    for (int k = 1; k <= 4; k++) begin
      sample();
      chk("t1_lat_low", 32'(rsp_valid), 0);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_ready_add", 32'(req_ready), 0);
      adv();
    end
    sample();
    chk("t1_lat_high", 32'(rsp_valid), 1);
    chk("t1_popped", 32'(sb.size()), 0);
    adv();
    sample();
    chk("t1_valid_drop", 32'(rsp_valid), 0);
    chk("t1_busy_drop", 32'(busy), 0);
    adv();

    // Overflow on requester 2.
    set_op(2, 16'hFFFF, 16'h0001); req_valid = 4'b0100; push(2);
    sample(); chk("ovf_ready", 32'(req_ready), 32'b0100); adv();
    req_valid = '0;
    drain("ovf", 20);

    // Carry chain across every nibble, requester 1.
    set_op(1, 16'h0FFF, 16'h0001); req_valid = 4'b0010; push(1);
    sample(); chk("cc_ready", 32'(req_ready), 32'b0010); adv();
    req_valid = '0;
    drain("cc", 20);

    // Reset two cycles into ADD on requester 2: no response, pointer reset.
    set_op(2, 16'h5555, 16'h3333); req_valid = 4'b0100;
    sample(); chk("rm_ready", 32'(req_ready), 32'b0100); adv();
    req_valid = '0;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("rm_busy_now", 32'(busy), 0);
    chk("rm_valid_now", 32'(rsp_valid), 0);
    adv();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sample(); chk("rm_no_rsp", 32'(rsp_valid), 0); adv();
    end

    // Round-robin with every requester valid: 0,1,2,3,0.
    set_op(0, 16'h0001, 16'hFFFF);
    set_op(1, 16'h8000, 16'h8000);
    set_op(2, 16'hABCD, 16'h1234);
    set_op(3, 16'hF0F0, 16'h0F10);
    req_valid = 4'b1111;
    push(0); push(1); push(2); push(3); push(0);
    drain("rr1", 60);
    // Drop requester 1: 2,3,0,2.
    req_valid = 4'b1101;
    push(2); push(3); push(0); push(2);
    drain("rr2", 60);
    req_valid = '0;
    tick();

    // Back-pressure: hold the response for 10 cycles while requester 1 waits.
    rsp_ready = 1'b0;
    set_op(0, 16'h7777, 16'h1111); req_valid = 4'b0001; push(0);
    sample(); chk("bp_ready", 32'(req_ready), 32'b0001); adv();
    req_valid = 4'b0010; set_op(1, 16'h0102, 16'h0304);
    got = 1'b0;
    for (int k = 0; k < 12; k++) begin
      sample();
      if (rsp_valid) begin got = 1'b1; break; end
      adv();
    end
    chk("bp_seen", 32'(got), 1);
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_sum", 32'(rsp_sum), 32'h8888);
      chk("bp_id", 32'(rsp_id), 0);
      chk("bp_ready_lo", 32'(req_ready), 0);
      adv();
      sample();
    end
    adv();
    rsp_ready = 1'b1;
    sample();
    chk("bp_rel_ready", 32'(req_ready), 0);
    chk("bp_popped", 32'(sb.size()), 0);
    adv();
    push(1);
    sample();
    chk("bp_next_accept", 32'(req_ready), 32'b0010);
    adv();
    req_valid = '0;
    drain("bp", 20);

    tick();
    chk("end_busy", 32'(busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
